// File: rtl/simd_pkg.sv
// Shared constants and types for the matrix-multiply front end.
// Holds the operand geometry, the packed row type and the loader state encoding.
package simd_pkg;

    localparam int N      = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    typedef logic [N*DATA_W-1:0] row_t;

    typedef enum logic [1:0] {
        LOAD_A    = 2'd0,
        LOAD_B    = 2'd1,
        START     = 2'd2,
        WAIT_DONE = 2'd3
    } loader_state_t;

endpackage

// File: rtl/row_packer.sv
// Assembles N stream words into one packed row and emits it with a one-cycle row_done pulse.
// Word j of the row lands in bits [j*DATA_W +: DATA_W].
module row_packer #(
    parameter int N      = 4,
    parameter int DATA_W = 32,
    localparam int COL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                clear,
    input  logic [DATA_W-1:0]   data,
    output logic [COL_W-1:0]    col,
    output logic                row_done,
    output logic [N*DATA_W-1:0] row_data
);

    logic [DATA_W-1:0]   slot_reg [N];
    logic [COL_W-1:0]    col_reg;
    logic                row_done_reg;
    logic [N*DATA_W-1:0] row_data_reg;
    logic [N*DATA_W-1:0] merged;

    // The completing word is merged in directly so the row leaves one cycle after its last beat.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_merge
            assign merged[gi*DATA_W +: DATA_W] = (col_reg == COL_W'(gi)) ? data : slot_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg      <= '0;
            row_done_reg <= 1'b0;
            row_data_reg <= '0;
            for (int i = 0; i < N; i++) begin
                slot_reg[i] <= '0;
            end
        end else begin
            row_done_reg <= 1'b0;
            if (clear) begin
                col_reg <= '0;
            end else if (push) begin
                slot_reg[col_reg] <= data;
                if (col_reg == COL_W'(N-1)) begin
                    col_reg      <= '0;
                    row_done_reg <= 1'b1;
                    row_data_reg <= merged;
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
            end
        end
    end

    assign col      = col_reg;
    assign row_done = row_done_reg;
    assign row_data = row_data_reg;

endmodule

// File: rtl/matrix_loader.sv
// Loads operand matrices A then B from a word stream into the operand RAMs, starts the PE,
// and holds the stream off until the PE signals completion with a fresh rising edge of pe_stop.
module matrix_loader
    import simd_pkg::*;
#(
    parameter int N      = simd_pkg::N,
    parameter int DATA_W = simd_pkg::DATA_W,
    parameter int CNT_W  = simd_pkg::CNT_W,
    localparam int COL_W  = (N > 1) ? $clog2(N) : 1,
    localparam int WORD_W = $clog2(2*N*N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_last,
    output logic                wr_en,
    output logic                wr_sel,
    output logic [COL_W-1:0]    wr_row,
    output logic [N*DATA_W-1:0] wr_data,
    output logic                pe_valid,
    input  logic                pe_stop,
    output logic                busy,
    output logic                frame_err,
    output logic [CNT_W-1:0]    frames_done
);

    loader_state_t     state_reg, state_next;
    logic [COL_W-1:0]  row_reg, row_next;
    logic [WORD_W-1:0] word_reg, word_next;
    logic [CNT_W-1:0]  frames_done_reg, frames_done_next;
    logic              wr_sel_reg;
    logic [COL_W-1:0]  wr_row_reg;
    logic              pe_valid_reg;
    logic              busy_reg;
    logic              frame_err_reg;
    logic              pe_stop_prev_reg;

    logic              beat;
    logic              last_idx;
    logic              err;
    logic              push;
    logic              row_end;
    logic              stop_rise;
    logic [COL_W-1:0]  col;

    assign s_ready   = (state_reg == LOAD_A) || (state_reg == LOAD_B);
    assign beat      = s_valid && s_ready;
    assign last_idx  = (word_reg == WORD_W'(2*N*N-1));
    // A misplaced or missing s_last kills the beat before it reaches the packer.
    assign err       = beat && (s_last != last_idx);
    assign push      = beat && !err;
    assign row_end   = push && (col == COL_W'(N-1));
    assign stop_rise = pe_stop && !pe_stop_prev_reg;

    row_packer #(
        .N      (N),
        .DATA_W (DATA_W)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .clear    (err),
        .data     (s_data),
        .col      (col),
        .row_done (wr_en),
        .row_data (wr_data)
    );

    always_comb begin
        state_next       = state_reg;
        row_next         = row_reg;
        word_next        = word_reg;
        frames_done_next = frames_done_reg;
        unique case (state_reg)
            LOAD_A, LOAD_B: begin
                if (err) begin
                    state_next = LOAD_A;
                    row_next   = '0;
                    word_next  = '0;
                end else if (push) begin
                    word_next = word_reg + 1'b1;
                    if (row_end) begin
                        if (row_reg == COL_W'(N-1)) begin
                            row_next = '0;
                            if (state_reg == LOAD_A) begin
                                state_next = LOAD_B;
                            end else begin
                                state_next = START;
                                word_next  = '0;
                            end
                        end else begin
                            row_next = row_reg + 1'b1;
                        end
                    end
                end
            end
            START: begin
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (stop_rise) begin
                    state_next       = LOAD_A;
                    row_next         = '0;
                    word_next        = '0;
                    frames_done_next = frames_done_reg + 1'b1;
                end
            end
            default: begin
                state_next = LOAD_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= LOAD_A;
            row_reg          <= '0;
            word_reg         <= '0;
            frames_done_reg  <= '0;
            wr_sel_reg       <= 1'b0;
            wr_row_reg       <= '0;
            pe_valid_reg     <= 1'b0;
            busy_reg         <= 1'b0;
            frame_err_reg    <= 1'b0;
            pe_stop_prev_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            row_reg          <= row_next;
            word_reg         <= word_next;
            frames_done_reg  <= frames_done_next;
            pe_valid_reg     <= (state_reg == START);
            busy_reg         <= (state_next == START) || (state_next == WAIT_DONE);
            frame_err_reg    <= err;
            pe_stop_prev_reg <= pe_stop;
            if (row_end) begin
                wr_sel_reg <= (state_reg == LOAD_B);
                wr_row_reg <= row_reg;
            end
        end
    end

    assign wr_sel      = wr_sel_reg;
    assign wr_row      = wr_row_reg;
    assign pe_valid    = pe_valid_reg;
    assign busy        = busy_reg;
    assign frame_err   = frame_err_reg;
    assign frames_done = frames_done_reg;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: nominal frames, back-pressure, framing errors,
// stale pe_stop, reset during operation and frames_done wrap.
module tb_matrix_loader;

    localparam int N      = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic [DATA_W-1:0]   s_data = '0;
    logic                s_last = 1'b0;
    logic                wr_en;
    logic                wr_sel;
    logic [1:0]          wr_row;
    logic [N*DATA_W-1:0] wr_data;
    logic                pe_valid;
    logic                pe_stop = 1'b0;
    logic                busy;
    logic                frame_err;
    logic [CNT_W-1:0]    frames_done;

    matrix_loader dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_row      (wr_row),
        .wr_data     (wr_data),
        .pe_valid    (pe_valid),
        .pe_stop     (pe_stop),
        .busy        (busy),
        .frame_err   (frame_err),
        .frames_done (frames_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    int wr_cnt = 0;
    int pe_cnt = 0;
    int err_cnt = 0;
    int pe_cyc = -1;
    int last_beat_cyc = 0;
    logic         q_sel  [$];
    logic [1:0]   q_row  [$];
    logic [127:0] q_data [$];

    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            q_sel.push_back(wr_sel);
            q_row.push_back(wr_row);
            q_data.push_back(wr_data);
            $display("cyc=%0d wr_en sel=%0d row=%0d data=%h", cyc, wr_sel, wr_row, wr_data);
        end
        if (pe_valid) begin
            pe_cnt++;
            pe_cyc = cyc;
            $display("cyc=%0d pe_valid", cyc);
        end
        if (frame_err) begin
            err_cnt++;
            $display("cyc=%0d frame_err", cyc);
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        wr_cnt  = 0;
        pe_cnt  = 0;
        err_cnt = 0;
        pe_cyc  = -1;
        q_sel.delete();
        q_row.delete();
        q_data.delete();
    endtask

    task automatic send_word(input logic [31:0] d, input bit last);
        int w;
        w = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!s_ready) begin
            check("ready_timeout", 128'(s_ready), 128'(1));
        end else begin
            last_beat_cyc = cyc;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int first, input int nwords, input int last_at,
                              input bit toggle, input int gap_at, input int gap_len);
        for (int i = 0; i < nwords; i++) begin
            if (toggle && i > 0) idle(1);
            if (i == gap_at) idle(gap_len);
            send_word(32'(first + i), i == last_at);
        end
    endtask

    task automatic check_rows(input string tag, input int first, input int nrows);
        logic [127:0] exp;
        int b;
        check({tag, "_wr_cnt"}, 128'(wr_cnt), 128'(nrows));
        for (int k = 0; k < nrows; k++) begin
            b   = first + 4*k;
            exp = {32'(b+3), 32'(b+2), 32'(b+1), 32'(b)};
            check($sformatf("%s_sel%0d", tag, k), 128'(q_sel[k]), 128'(k >= N));
            check($sformatf("%s_row%0d", tag, k), 128'(q_row[k]), 128'(k % N));
            check($sformatf("%s_data%0d", tag, k), q_data[k], exp);
        end
    endtask

    task automatic complete_op(input string tag, input logic [15:0] exp_done);
        pe_stop = 1'b0;
        idle(1);
        pe_stop = 1'b1;
        idle(1);
        check({tag, "_frames_done"}, 128'(frames_done), 128'(exp_done));
        check({tag, "_ready_after"}, 128'(s_ready), 128'(1));
        check({tag, "_busy_after"}, 128'(busy), 128'(0));
        pe_stop = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"}, 128'(wr_en), 128'(0));
        check({tag, "_wr_sel"}, 128'(wr_sel), 128'(0));
        check({tag, "_wr_row"}, 128'(wr_row), 128'(0));
        check({tag, "_wr_data"}, wr_data, 128'(0));
        check({tag, "_pe_valid"}, 128'(pe_valid), 128'(0));
        check({tag, "_frame_err"}, 128'(frame_err), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_frames_done"}, 128'(frames_done), 128'(0));
        check({tag, "_s_ready"}, 128'(s_ready), 128'(1));
    endtask

    initial begin
        logic [127:0] first_row;
        first_row = 128'h00000004_00000003_00000002_00000001;

        // Reset state
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        check_reset_outputs("reset");

        // 1: nominal back-to-back frame
        clear_mon();
        send_frame(1, 32, 31, 1'b0, -1, 0);
        idle(3);
        check_rows("t1", 1, 8);
        check("t1_first_row", q_data[0], first_row);
        check("t1_pe_cnt", 128'(pe_cnt), 128'(1));
        check("t1_pe_latency", 128'(pe_cyc), 128'(last_beat_cyc + 2));
        check("t1_busy", 128'(busy), 128'(1));
        check("t1_ready_blocked", 128'(s_ready), 128'(0));
        idle(16);
        complete_op("t1", 16'd1);

        // 2: back-pressure with toggling valid and a 7-cycle gap inside row 2
        clear_mon();
        send_frame(1, 32, 31, 1'b1, 10, 7);
        idle(3);
        check_rows("t2", 1, 8);
        check("t2_pe_cnt", 128'(pe_cnt), 128'(1));
        check("t2_pe_latency", 128'(pe_cyc), 128'(last_beat_cyc + 2));
        complete_op("t2", 16'd2);

        // 3a: early s_last on word 10, then a good frame
        clear_mon();
        send_frame(1, 10, 9, 1'b0, -1, 0);
        idle(3);
        check("t3a_err_cnt", 128'(err_cnt), 128'(1));
        check("t3a_pe_cnt", 128'(pe_cnt), 128'(0));
        check("t3a_wr_cnt", 128'(wr_cnt), 128'(2));
        check("t3a_ready", 128'(s_ready), 128'(1));
        clear_mon();
        send_frame(101, 32, 31, 1'b0, -1, 0);
        idle(3);
        check_rows("t3v", 101, 8);
        check("t3v_pe_cnt", 128'(pe_cnt), 128'(1));
        check("t3v_err_cnt", 128'(err_cnt), 128'(0));
        complete_op("t3v", 16'd3);

        // 3b: 32 words with no s_last
        clear_mon();
        send_frame(201, 32, -1, 1'b0, -1, 0);
        idle(3);
        check("t3b_err_cnt", 128'(err_cnt), 128'(1));
        check("t3b_wr_cnt", 128'(wr_cnt), 128'(7));
        check("t3b_pe_cnt", 128'(pe_cnt), 128'(0));
        check("t3b_busy", 128'(busy), 128'(0));
        check("t3b_ready", 128'(s_ready), 128'(1));
        check("t3b_frames_done", 128'(frames_done), 128'(3));

        // 4: stale pe_stop held high from the previous operation
        clear_mon();
        send_frame(1, 32, 31, 1'b0, -1, 0);
        idle(3);
        pe_stop = 1'b1;
        idle(2);
        check("t4_first_done", 128'(frames_done), 128'(4));
        clear_mon();
        send_frame(1, 32, 31, 1'b0, -1, 0);
        idle(10);
        check("t4_stale_busy", 128'(busy), 128'(1));
        check("t4_stale_ready", 128'(s_ready), 128'(0));
        check("t4_stale_frames", 128'(frames_done), 128'(4));
        check("t4_pe_cnt", 128'(pe_cnt), 128'(1));
        pe_stop = 1'b0;
        idle(1);
        pe_stop = 1'b1;
        idle(1);
        check("t4_rise_frames", 128'(frames_done), 128'(5));
        check("t4_rise_ready", 128'(s_ready), 128'(1));
        idle(5);
        check("t4_single_completion", 128'(frames_done), 128'(5));
        pe_stop = 1'b0;

        // 5a: reset one cycle after the 20th beat
        clear_mon();
        send_frame(1, 20, -1, 1'b0, -1, 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_reset_outputs("t5a");
        idle(4);
        check("t5a_pe_cnt", 128'(pe_cnt), 128'(0));

        // 5b: reset while in START
        clear_mon();
        send_frame(1, 32, 31, 1'b0, -1, 0);
        check("t5b_in_start_busy", 128'(busy), 128'(1));
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_reset_outputs("t5b");
        idle(5);
        check("t5b_pe_cnt", 128'(pe_cnt), 128'(0));
        check("t5b_busy_later", 128'(busy), 128'(0));

        // 6: frames_done wraps from 0xFFFF to 0
        force dut.frames_done_reg = 16'hFFFF;
        #1;
        release dut.frames_done_reg;
        check("t6_preload", 128'(frames_done), 128'(16'hFFFF));
        clear_mon();
        send_frame(1, 32, 31, 1'b0, -1, 0);
        idle(5);
        check("t6_pe_cnt", 128'(pe_cnt), 128'(1));
        complete_op("t6", 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_loader.md
Name: matrix_loader

Overview:
Upstream stage of the matrix-multiply PE. Receives a 32-word stream carrying operand matrix A (16 words) followed by operand matrix B (16 words), both row-major. Packs each group of 4 words into a 128-bit row and writes it into the fetch unit's A/B operand RAMs. After the last row is written it pulses the PE start strobe, then blocks the stream until the PE reports completion.

Parameters:
N, 4, matrix dimension; rows per matrix and words per row.
DATA_W, 32, element width in bits.
CNT_W, 16, width of the completed-frame counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_valid  in  1  stream word valid
s_ready  out  1  stream word ready
s_data  in  DATA_W  stream word
s_last  in  1  marks the final word of a frame
wr_en  out  1  operand RAM row write strobe
wr_sel  out  1  0 = RAM A, 1 = RAM B
wr_row  out  $clog2(N)  row address
wr_data  out  N*DATA_W  packed row; word j occupies bits [j*DATA_W +: DATA_W]
pe_valid  out  1  one-cycle start strobe to PE
pe_stop  in  1  PE done level; may remain high between operations
busy  out  1  high in START and WAIT_DONE
frame_err  out  1  one-cycle framing error pulse
frames_done  out  CNT_W  count of completed PE operations

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state updates occur on the rising edge of clk.
- Reset values: state = LOAD_A; col, row and word counters = 0; row buffer = 0; wr_en, wr_sel, wr_row, wr_data, pe_valid, frame_err, busy = 0; frames_done = 0.
- States:
  - LOAD_A, LOAD_B: s_ready = 1.
  - START, WAIT_DONE: s_ready = 0.
- Beat: s_valid && s_ready. Each beat stores s_data into row buffer slot col, then increments col.
- Row completion: on the beat with col == N-1, the next cycle drives wr_en = 1 for exactly one cycle, with these registered values:
  - wr_data = full row, including the current word;
  - wr_row = row;
  - wr_sel = 0 in LOAD_A, 1 in LOAD_B.
  - col wraps to 0 and row increments.
- Transitions:
  - LOAD_A to LOAD_B: row wraps after row N-1 of A.
  - LOAD_B to START: completion of row N-1 of B, i.e. beat 2N²-1 = 31.
- Timing of the last beat, accepted in cycle T:
  - T+1: wr_en for B row 3; state = START.
  - T+2: pe_valid = 1 (exactly one cycle); state = WAIT_DONE.
- Stale done: pe_stop may still be high from the previous operation. WAIT_DONE acts only on a rising edge of pe_stop (registered previous value low, current value high).
- On that edge: frames_done increments, wrapping modulo 2^CNT_W; state returns to LOAD_A with all counters 0.
- Framing rules, with word index 0..31 counted within the frame:
  - s_last on a beat with index < 31, or no s_last on index 31: frame_err pulses one cycle after the beat.
  - Counters and state then return to LOAD_A, row 0, col 0, and the beat is discarded.
  - For an error on index 31, no wr_en and no pe_valid are issued.
  - Rows already written by the aborted frame remain in RAM. This is harmless because the PE is not started.
- Back-pressure: s_valid low mid-row holds col and the row buffer unchanged. Gaps of any length are legal.
- Reset mid-operation: an in-flight frame is discarded. No pe_valid is issued after rst, even if rst arrives in START.
- busy is registered: busy = 1 exactly when state is START or WAIT_DONE.

Decomposition:
- Shared package simd_pkg:
  - N and DATA_W constants;
  - row_t typedef (N×DATA_W packed);
  - loader state enum {LOAD_A, LOAD_B, START, WAIT_DONE}.
- Sub-module row_packer: word-to-row shift/assemble buffer with col counter. Outputs a row_done pulse and the packed row.
- The FSM, the frame checking and frames_done stay in matrix_loader.

Test Plan:
1. Nominal frame: stream words 1..32 back-to-back, s_last on word 32.
   - 8 wr_en pulses, sequence (sel,row) = (0,0)…(0,3),(1,0)…(1,3).
   - First write: wr_data = {4,3,2,1} (word 1 in the LSBs).
   - pe_valid exactly 2 cycles after the last beat.
   - Raise pe_stop after 20 cycles: frames_done = 1, s_ready = 1 on the next cycle.
2. Back-pressure: same frame with s_valid toggling every other cycle plus a 7-cycle gap inside row 2.
   - Identical wr_data values to test 1; no extra or missing wr_en.
3. Framing errors:
   - s_last on word 10: frame_err pulses once, no pe_valid; the following valid frame completes normally.
   - 32 words with no s_last: frame_err, no 8th wr_en, no pe_valid.
4. Stale stop: hold pe_stop high continuously from the prior op, then send a frame.
   - Loader stays in WAIT_DONE, busy = 1, s_ready = 0.
   - Drop pe_stop for 1 cycle then raise it: exactly one completion.
5. Reset mid-op: assert rst one cycle after the 20th beat, and separately during START.
   - All outputs are at reset values the next cycle; pe_valid is never seen; frames_done = 0.
6. Counter wrap: preload frames_done to 0xFFFF via a force, then complete one frame.
   - frames_done = 0x0000.
